// File: rtl/pstats_trig_gen_if.sv
// Start/stop, configuration and trigger-output bundle for pstats_trig_gen.
interface pstats_trig_gen_if #(
  parameter int g_trig_width = 10,
  parameter int g_cnt_width  = 16
);
  logic                    start_i;
  logic                    stop_i;
  logic                    mode_i;
  logic [g_cnt_width-1:0]  period_i;
  logic [g_cnt_width-1:0]  pulse_len_i;
  logic [g_cnt_width-1:0]  stagger_i;
  logic [g_cnt_width-1:0]  burst_len_i;
  logic [7:0]              rand_thr_i;
  logic [g_trig_width-1:0] trig_o;
  logic                    busy_o;
  logic                    done_p_o;

  modport master (
    output start_i, stop_i, mode_i, period_i, pulse_len_i, stagger_i, burst_len_i, rand_thr_i,
    input  trig_o, busy_o, done_p_o
  );

  modport slave (
    input  start_i, stop_i, mode_i, period_i, pulse_len_i, stagger_i, burst_len_i, rand_thr_i,
    output trig_o, busy_o, done_p_o
  );
endinterface

// File: rtl/pstats_trig_gen.sv
// Multi-channel staggered trigger generator: per-channel slots of a latched period, periodic or
// LFSR-gated firing, finite/endless bursts and a graceful stop that lets running pulses finish.
module pstats_trig_gen #(
  parameter int          g_trig_width = 10,
  parameter int          g_cnt_width  = 16,
  parameter logic [15:0] g_lfsr_seed  = 16'hACE1
) (
  input logic              clk_i,
  input logic              rst_n_i,
  pstats_trig_gen_if.slave bus
);
  localparam int OffW = g_cnt_width + $clog2(g_trig_width);

  typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;
  typedef logic [g_cnt_width-1:0] cnt_t;

  state_t                  state;
  logic                    busy;
  logic                    done_p;
  logic                    mode_q;
  cnt_t                    per_q;
  cnt_t                    pl_q;
  cnt_t                    burst_q;
  logic [7:0]              thr_q;
  cnt_t                    per_c;
  cnt_t                    pl_c;
  logic                    accept;
  logic                    all_done;

  logic [OffW-1:0]         off      [g_trig_width];
  cnt_t                    ph       [g_trig_width];
  cnt_t                    slot_cnt [g_trig_width];
  logic [15:0]             lfsr     [g_trig_width];
  logic [g_trig_width-1:0] waiting;
  logic [g_trig_width-1:0] act;
  logic [g_trig_width-1:0] fired;
  logic [g_trig_width-1:0] ch_done;
  logic [g_trig_width-1:0] trig;
  logic [g_trig_width-1:0] fire_now;
  logic [g_trig_width-1:0] ends_slot;
  logic [g_trig_width-1:0] ends_last;
  logic [g_trig_width-1:0] begin_slot;

  function automatic logic [15:0] seed_of(input int n);
    logic [15:0] s;
    s = g_lfsr_seed ^ 16'(n);
    return (s == 16'h0000) ? 16'h0001 : s;
  endfunction

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  assign accept   = (state == IDLE) && bus.start_i && !bus.stop_i;
  assign per_c    = (bus.period_i < cnt_t'(2)) ? cnt_t'(2) : bus.period_i;
  assign pl_c     = (bus.pulse_len_i >= per_c) ? per_c - cnt_t'(1) : bus.pulse_len_i;
  assign all_done = &(ch_done | ends_last);

  // A stop sampled on a slot boundary suppresses that slot as well.
  always_comb begin
    fire_now   = '0;
    ends_slot  = '0;
    ends_last  = '0;
    begin_slot = '0;
    for (int n = 0; n < g_trig_width; n++) begin
      fire_now[n]   = !mode_q || (lfsr[n][7:0] < thr_q);
      ends_slot[n]  = act[n] && (ph[n] == per_q - cnt_t'(1));
      ends_last[n]  = ends_slot[n] && (burst_q != '0) && (slot_cnt[n] == burst_q - cnt_t'(1));
      begin_slot[n] = (state == RUN) && !bus.stop_i &&
                      ((waiting[n] && (off[n] == '0)) || (ends_slot[n] && !ends_last[n]));
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done_p  <= 1'b0;
      mode_q  <= 1'b0;
      per_q   <= '0;
      pl_q    <= '0;
      burst_q <= '0;
      thr_q   <= '0;
    end else begin
      done_p <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          state   <= RUN;
          busy    <= 1'b1;
          mode_q  <= bus.mode_i;
          per_q   <= per_c;
          pl_q    <= pl_c;
          burst_q <= bus.burst_len_i;
          thr_q   <= bus.rand_thr_i;
        end
        RUN: if (bus.stop_i) begin
          state <= STOP;
        end else if (all_done) begin
          state  <= IDLE;
          busy   <= 1'b0;
          done_p <= 1'b1;
        end
        STOP: if (trig == '0) begin
          state  <= IDLE;
          busy   <= 1'b0;
          done_p <= 1'b1;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // LFSRs are reseeded on every accepted start so equal configs give equal traces.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int n = 0; n < g_trig_width; n++) begin
        off[n]      <= '0;
        ph[n]       <= '0;
        slot_cnt[n] <= '0;
        lfsr[n]     <= seed_of(n);
      end
      waiting <= '0;
      act     <= '0;
      fired   <= '0;
      ch_done <= '0;
      trig    <= '0;
    end else if (accept) begin
      for (int n = 0; n < g_trig_width; n++) begin
        off[n]      <= OffW'(bus.stagger_i) * OffW'(n);
        ph[n]       <= '0;
        slot_cnt[n] <= '0;
        lfsr[n]     <= seed_of(n);
      end
      waiting <= '1;
      act     <= '0;
      fired   <= '0;
      ch_done <= '0;
      trig    <= '0;
    end else if (state == IDLE) begin
      waiting <= '0;
      act     <= '0;
      trig    <= '0;
    end else begin
      for (int n = 0; n < g_trig_width; n++) begin
        if (begin_slot[n]) begin
          waiting[n] <= 1'b0;
          act[n]     <= 1'b1;
          ph[n]      <= '0;
          fired[n]   <= fire_now[n];
          trig[n]    <= fire_now[n] && (pl_q != '0);
          lfsr[n]    <= lfsr_step(lfsr[n]);
          if (ends_slot[n]) slot_cnt[n] <= slot_cnt[n] + cnt_t'(1);
        end else begin
          if (waiting[n] && (state == RUN) && (off[n] != '0)) off[n] <= off[n] - OffW'(1);
          if (act[n]) begin
            ph[n]   <= ph[n] + cnt_t'(1);
            trig[n] <= fired[n] && ((ph[n] + cnt_t'(1)) < pl_q);
            if (ends_slot[n]) begin
              act[n]      <= 1'b0;
              trig[n]     <= 1'b0;
              slot_cnt[n] <= slot_cnt[n] + cnt_t'(1);
              if (ends_last[n]) ch_done[n] <= 1'b1;
            end
          end
        end
      end
    end
  end

  assign bus.trig_o   = trig;
  assign bus.busy_o   = busy;
  assign bus.done_p_o = done_p;
endmodule

// File: tb/tb_pstats_trig_gen.sv
// Scoreboard bench for pstats_trig_gen: a slot-level reference model predicts every output cycle.
module tb_pstats_trig_gen;
  localparam int W     = 4;
  localparam int CW    = 16;
  localparam int NSLOT = 1024;
  localparam int INF   = 32'h3FFF_FFFF;

  typedef struct {
    logic [W-1:0] trig;
    logic         busy;
    logic         done;
  } exp_t;

  logic clk_i   = 1'b0;
  logic rst_n_i = 1'b1;

  pstats_trig_gen_if #(.g_trig_width(W), .g_cnt_width(CW)) bus ();

  pstats_trig_gen #(.g_trig_width(W), .g_cnt_width(CW), .g_lfsr_seed(16'hACE1)) dut (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .bus     (bus)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;
  int rec    = 0;
  exp_t expq[$];
  logic [W-1:0] tr_a[$];
  logic [W-1:0] tr_b[$];
  int rise0[$];
  int rise_hi[$];
  int fall0    = -1;
  int done_cyc = -1;

  // Reference model state for the run in flight
  int m_k, m_per, m_pl, m_stg, m_burst, m_s, m_e, m_d;
  bit [NSLOT-1:0] fire_tab [W];

  function automatic logic [15:0] ref_lfsr_next(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  function automatic logic [W-1:0] trig_m(input int c);
    logic [W-1:0] r;
    int base, j, ph, t;
    r = '0;
    for (int n = 0; n < W; n++) begin
      base = m_k + 1 + n * m_stg;
      if (c >= base) begin
        j  = (c - base) / m_per;
        ph = (c - base) % m_per;
        t  = base + j * m_per;
        if ((m_burst == 0 || j < m_burst) && t < m_s && j < NSLOT && fire_tab[n][j] && ph < m_pl)
          r[n] = 1'b1;
      end
    end
    return r;
  endfunction

  initial begin : monitor
    exp_t e;
    logic [W-1:0] prev;
    prev = '0;
    forever begin
      @(posedge clk_i);
      #1;
      if (mon_en) begin
        if (expq.size() > 0) begin
          e = expq.pop_front();
          checks++;
          if (bus.trig_o !== e.trig || bus.busy_o !== e.busy || bus.done_p_o !== e.done) begin
            errors++;
            $display("FAIL sb cyc=%0d got trig=%b busy=%b done=%b want trig=%b busy=%b done=%b",
                     cyc, bus.trig_o, bus.busy_o, bus.done_p_o, e.trig, e.busy, e.done);
          end
        end else begin
          checks++;
          if (bus.trig_o !== '0 || bus.busy_o !== 1'b0 || bus.done_p_o !== 1'b0) begin
            errors++;
            $display("FAIL idle cyc=%0d got trig=%b busy=%b done=%b want all zero",
                     cyc, bus.trig_o, bus.busy_o, bus.done_p_o);
          end
        end
        if (bus.trig_o[0] && !prev[0]) rise0.push_back(cyc);
        if (!bus.trig_o[0] && prev[0]) fall0 = cyc;
        if (bus.trig_o[W-1] && !prev[W-1]) rise_hi.push_back(cyc);
        if (bus.done_p_o) done_cyc = cyc;
        if (rec == 1) tr_a.push_back(bus.trig_o);
        if (rec == 2) tr_b.push_back(bus.trig_o);
      end
      prev = bus.trig_o;
    end
  end

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  task automatic run(input int per_raw, input int pl_raw, input int stg, input int brst,
                     input bit md, input int thr, input int stop_after, input bit noise);
    logic [15:0] v;
    exp_t x;
    int e, lim, c;
    @(negedge clk_i);
    rise0.delete();
    rise_hi.delete();
    fall0    = -1;
    done_cyc = -1;
    m_k     = cyc + 1;
    m_per   = (per_raw < 2) ? 2 : per_raw;
    m_pl    = (pl_raw >= m_per) ? m_per - 1 : pl_raw;
    m_stg   = stg;
    m_burst = brst;
    for (int n = 0; n < W; n++) begin
      v = 16'hACE1 ^ 16'(n);
      if (v == 16'h0000) v = 16'h0001;
      for (int j = 0; j < NSLOT; j++) begin
        fire_tab[n][j] = !md || (int'(v[7:0]) < thr);
        v = ref_lfsr_next(v);
      end
    end
    m_e = (brst != 0) ? m_k + 1 + (W - 1) * stg + brst * m_per : INF;
    m_s = (stop_after > 0 && m_k + stop_after < m_e) ? m_k + stop_after : INF;
    if (m_s != INF) begin
      c = m_s;
      while (trig_m(c) != '0 && c < m_s + 10000) c++;
      m_d = c + 1;
    end else begin
      m_d = m_e;
    end
    for (int cc = m_k; cc <= m_d + 1; cc++) begin
      x.trig = (cc < m_d) ? trig_m(cc) : '0;
      x.busy = (cc < m_d);
      x.done = (cc == m_d);
      expq.push_back(x);
    end
    bus.period_i    = CW'(per_raw);
    bus.pulse_len_i = CW'(pl_raw);
    bus.stagger_i   = CW'(stg);
    bus.burst_len_i = CW'(brst);
    bus.mode_i      = md;
    bus.rand_thr_i  = 8'(thr);
    bus.stop_i      = 1'b0;
    bus.start_i     = 1'b1;
    lim = ((m_s < m_e) ? m_s : m_e) - 1;
    do begin
      @(negedge clk_i);
      e = cyc + 1;
      bus.stop_i  = (e == m_s);
      bus.start_i = noise && (e < lim) && ($urandom_range(0, 3) == 0);
      if (noise && e < lim) begin
        bus.period_i    = CW'($urandom);
        bus.pulse_len_i = CW'($urandom);
        bus.stagger_i   = CW'($urandom);
        bus.burst_len_i = CW'($urandom);
        bus.mode_i      = 1'($urandom);
        bus.rand_thr_i  = 8'($urandom);
      end
    end while (cyc < m_d + 1);
    bus.start_i = 1'b0;
    bus.stop_i  = 1'b0;
    repeat (3) @(negedge clk_i);
  endtask

  initial begin : watchdog
    #900_000;
    $display("FAIL watchdog cyc=%0d got no completion want summary", cyc);
    $fatal(1);
  end

  initial begin : stim
    bit found;
    int per, stg, brst, len_e, stop_after;
    bus.start_i = 1'b0;  bus.stop_i = 1'b0;  bus.mode_i = 1'b0;
    bus.period_i = '0;   bus.pulse_len_i = '0; bus.stagger_i = '0;
    bus.burst_len_i = '0; bus.rand_thr_i = '0;
    #1 rst_n_i = 1'b0;
    #2;
    check("rst_trig", int'(bus.trig_o), 0);
    check("rst_busy", int'(bus.busy_o), 0);
    check("rst_done", int'(bus.done_p_o), 0);
    repeat (2) @(negedge clk_i);
    rst_n_i = 1'b1;
    mon_en  = 1'b1;
    repeat (2) @(negedge clk_i);

    // Four staggered channels, three slots each
    run(32, 1, 1, 3, 1'b0, 0, 0, 1'b1);
    check("t1_done_lat", done_cyc - m_k, 100);
    check("t1_rise0_cnt", rise0.size(), 3);
    if (rise0.size() == 3) begin
      check("t1_rise0_a", rise0[0] - m_k, 1);
      check("t1_rise0_b", rise0[1] - m_k, 33);
      check("t1_rise0_c", rise0[2] - m_k, 65);
    end
    check("t1_rise3_first", (rise_hi.size() > 0) ? rise_hi[0] - m_k : -1, 4);

    // Clamped period/pulse, endless, stopped
    run(1, 5, 2, 0, 1'b0, 0, 25, 1'b1);
    check("t2_done_seen", done_cyc - m_k, m_d - m_k);

    // Graceful stop three cycles into a pulse
    run(32, 10, 0, 5, 1'b0, 0, 4, 1'b0);
    check("t4_pulses", rise0.size(), 1);
    check("t4_width", (rise0.size() > 0) ? fall0 - rise0[0] : -1, 10);
    check("t4_done_after_fall", done_cyc - fall0, 1);

    // Random mode
    run(2, 1, 0, 100, 1'b1, 0, 0, 1'b0);
    check("t3_thr0_fires", rise0.size(), 0);
    run(2, 1, 0, 100, 1'b1, 128, 0, 1'b0);
    checks++;
    if (rise0.size() < 30 || rise0.size() > 70) begin
      errors++;
      $display("FAIL t3_thr128_fires got=%0d want 30..70", rise0.size());
    end
    rec = 1;
    run(5, 2, 1, 20, 1'b1, 100, 0, 1'b0);
    rec = 2;
    run(5, 2, 1, 20, 1'b1, 100, 0, 1'b0);
    rec = 0;
    found = (tr_a.size() == tr_b.size()) && (tr_a.size() > 0);
    foreach (tr_a[i]) if (found && tr_a[i] != tr_b[i]) found = 1'b0;
    check("t3_same_seed_trace", int'(found), 1);

    // start and stop together while idle
    @(negedge clk_i);
    bus.start_i = 1'b1;
    bus.stop_i  = 1'b1;
    @(negedge clk_i);
    bus.start_i = 1'b0;
    bus.stop_i  = 1'b0;
    repeat (3) @(negedge clk_i);
    check("t6_start_stop_busy", int'(bus.busy_o), 0);

    for (int r = 0; r < 8; r++) begin
      per  = $urandom_range(1, 20);
      stg  = $urandom_range(0, 6);
      brst = $urandom_range(0, 6);
      len_e = 1 + (W - 1) * stg + brst * ((per < 2) ? 2 : per);
      if (brst == 0) stop_after = $urandom_range(1, 80);
      else if ($urandom_range(0, 1) == 1) stop_after = $urandom_range(1, len_e - 1);
      else stop_after = 0;
      run(per, $urandom_range(0, 25), stg, brst, 1'($urandom), $urandom_range(0, 255),
          stop_after, 1'b1);
    end

    // Reset in the middle of a running pulse
    mon_en = 1'b0;
    @(negedge clk_i);
    bus.period_i = CW'(8);  bus.pulse_len_i = CW'(4); bus.stagger_i = '0;
    bus.burst_len_i = '0;   bus.mode_i = 1'b0;        bus.start_i = 1'b1;
    @(negedge clk_i);
    bus.start_i = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(posedge clk_i);
      #1;
      if (bus.trig_o[0]) found = 1'b1;
    end
    check("t5_trig_seen", int'(found), 1);
    #2 rst_n_i = 1'b0;
    #1;
    check("t5_async_trig", int'(bus.trig_o), 0);
    check("t5_async_busy", int'(bus.busy_o), 0);
    repeat (2) @(negedge clk_i);
    rst_n_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk_i);
      #1;
      check("t5_post_rst_outs", int'({bus.trig_o, bus.busy_o, bus.done_p_o}), 0);
    end
    mon_en = 1'b1;
    repeat (3) @(negedge clk_i);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
